// File: rtl/jelly_img_alpha_blend_pkg.sv
// Shared definitions for the alpha-blend layer: blend mode encodings and
// small elaboration-time helpers.
package jelly_img_alpha_blend_pkg;

    typedef enum logic [1:0] {
        BYPASS      = 2'd0,
        CONST       = 2'd1,
        PIXEL       = 2'd2,
        PIXEL_CONST = 2'd3
    } blend_mode_t;

    localparam int BLEND_LATENCY = 4;

    // Zero-width sideband still needs a one-bit port.
    function automatic int user_bits(input int width);
        return (width > 0) ? width : 1;
    endfunction

endpackage

// File: rtl/jelly_img_alpha_blend_layer_if.sv
// Image stream bundle for the alpha-blend layer: source side (two layers plus
// per-pixel alpha) and the blended output side.
interface jelly_img_alpha_blend_layer_if #(
    parameter int COMPONENTS  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ALPHA_WIDTH = 8,
    parameter int USER_BITS   = 1
);
    logic                             s_img_line_first;
    logic                             s_img_line_last;
    logic                             s_img_pixel_first;
    logic                             s_img_pixel_last;
    logic                             s_img_de;
    logic [USER_BITS-1:0]             s_img_user;
    logic                             s_img_valid;
    logic [COMPONENTS*DATA_WIDTH-1:0] s_img_data0;
    logic [COMPONENTS*DATA_WIDTH-1:0] s_img_data1;
    logic [ALPHA_WIDTH-1:0]           s_img_alpha;

    logic                             m_img_line_first;
    logic                             m_img_line_last;
    logic                             m_img_pixel_first;
    logic                             m_img_pixel_last;
    logic                             m_img_de;
    logic [USER_BITS-1:0]             m_img_user;
    logic                             m_img_valid;
    logic [COMPONENTS*DATA_WIDTH-1:0] m_img_data;

    modport master (
        output s_img_line_first, s_img_line_last, s_img_pixel_first, s_img_pixel_last,
        output s_img_de, s_img_user, s_img_valid, s_img_data0, s_img_data1, s_img_alpha,
        input  m_img_line_first, m_img_line_last, m_img_pixel_first, m_img_pixel_last,
        input  m_img_de, m_img_user, m_img_valid, m_img_data
    );

    modport slave (
        input  s_img_line_first, s_img_line_last, s_img_pixel_first, s_img_pixel_last,
        input  s_img_de, s_img_user, s_img_valid, s_img_data0, s_img_data1, s_img_alpha,
        output m_img_line_first, m_img_line_last, m_img_pixel_first, m_img_pixel_last,
        output m_img_de, m_img_user, m_img_valid, m_img_data
    );

endinterface

// File: rtl/jelly_img_alpha_blend_unit.sv
// One colour component of the blend: capture, alpha select/multiply,
// signed difference multiply, round and add back onto the background.
module jelly_img_alpha_blend_unit
    import jelly_img_alpha_blend_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ALPHA_WIDTH = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  blend_mode_t            mode,
    input  logic [ALPHA_WIDTH-1:0] const_alpha,
    input  logic [ALPHA_WIDTH-1:0] pixel_alpha,
    input  logic [DATA_WIDTH-1:0]  data0,
    input  logic [DATA_WIDTH-1:0]  data1,
    output logic [DATA_WIDTH-1:0]  data
);

    localparam int MIX_WIDTH  = 2*ALPHA_WIDTH + 1;
    localparam int PROD_WIDTH = DATA_WIDTH + ALPHA_WIDTH + 3;
    localparam logic [MIX_WIDTH-1:0]         MIX_HALF  = MIX_WIDTH'(1) << (ALPHA_WIDTH-1);
    localparam logic signed [PROD_WIDTH-1:0] PROD_HALF = $signed(PROD_WIDTH'(1) << (ALPHA_WIDTH-1));

    // Stretch so that all-ones means exactly unity gain.
    function automatic logic [ALPHA_WIDTH:0] ext_alpha(input logic [ALPHA_WIDTH-1:0] x);
        return {1'b0, x} + (ALPHA_WIDTH+1)'(x[ALPHA_WIDTH-1]);
    endfunction

    blend_mode_t                   st1_mode_reg;
    logic [ALPHA_WIDTH-1:0]        st1_calpha_reg;
    logic [ALPHA_WIDTH-1:0]        st1_palpha_reg;
    logic [DATA_WIDTH-1:0]         st1_data0_reg;
    logic [DATA_WIDTH-1:0]         st1_data1_reg;

    logic                          st2_bypass_reg;
    logic [ALPHA_WIDTH:0]          st2_alpha_reg;
    logic [DATA_WIDTH-1:0]         st2_data0_reg;
    logic [DATA_WIDTH-1:0]         st2_data1_reg;

    logic                          st3_bypass_reg;
    logic signed [PROD_WIDTH-1:0]  st3_prod_reg;
    logic [DATA_WIDTH-1:0]         st3_data0_reg;
    logic [DATA_WIDTH-1:0]         st3_data1_reg;

    logic [DATA_WIDTH-1:0]         data_reg;

    logic [MIX_WIDTH-1:0]          mix_prod;
    logic [ALPHA_WIDTH-1:0]        alpha_sel;
    logic signed [DATA_WIDTH:0]    diff;
    logic signed [PROD_WIDTH-1:0]  rounded;
    logic signed [PROD_WIDTH-1:0]  blended;

    // Pixel x constant alpha is rounded so a full-scale operand passes the
    // other one through unchanged (0xFF pixel alpha with 0x40 gives 0x40).
    always_comb begin
        mix_prod  = MIX_WIDTH'(st1_palpha_reg) * MIX_WIDTH'(ext_alpha(st1_calpha_reg)) + MIX_HALF;
        alpha_sel = '0;
        case (st1_mode_reg)
            CONST:       alpha_sel = st1_calpha_reg;
            PIXEL:       alpha_sel = st1_palpha_reg;
            PIXEL_CONST: alpha_sel = ALPHA_WIDTH'(mix_prod >> ALPHA_WIDTH);
            default:     alpha_sel = '0;
        endcase
    end

    assign diff    = $signed({1'b0, st2_data0_reg}) - $signed({1'b0, st2_data1_reg});
    assign rounded = (st3_prod_reg + PROD_HALF) >>> ALPHA_WIDTH;
    assign blended = rounded + $signed(PROD_WIDTH'(st3_data1_reg));

    always_ff @(posedge clk) begin
        if (reset) begin
            st1_mode_reg   <= BYPASS;
            st1_calpha_reg <= '0;
            st1_palpha_reg <= '0;
            st1_data0_reg  <= '0;
            st1_data1_reg  <= '0;
            st2_bypass_reg <= 1'b0;
            st2_alpha_reg  <= '0;
            st2_data0_reg  <= '0;
            st2_data1_reg  <= '0;
            st3_bypass_reg <= 1'b0;
            st3_prod_reg   <= '0;
            st3_data0_reg  <= '0;
            st3_data1_reg  <= '0;
            data_reg       <= '0;
        end else if (cke) begin
            st1_mode_reg   <= mode;
            st1_calpha_reg <= const_alpha;
            st1_palpha_reg <= pixel_alpha;
            st1_data0_reg  <= data0;
            st1_data1_reg  <= data1;

            st2_bypass_reg <= (st1_mode_reg == BYPASS);
            st2_alpha_reg  <= ext_alpha(alpha_sel);
            st2_data0_reg  <= st1_data0_reg;
            st2_data1_reg  <= st1_data1_reg;

            st3_bypass_reg <= st2_bypass_reg;
            st3_prod_reg   <= PROD_WIDTH'(diff) * $signed(PROD_WIDTH'(st2_alpha_reg));
            st3_data0_reg  <= st2_data0_reg;
            st3_data1_reg  <= st2_data1_reg;

            data_reg       <= st3_bypass_reg ? st3_data0_reg : DATA_WIDTH'(blended);
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/jelly_img_delay.sv
// Fixed-latency register delay line with clock enable and synchronous clear.
module jelly_img_delay #(
    parameter int LATENCY = 4,
    parameter int WIDTH   = 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             cke,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] m_data
);

    logic [LATENCY-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_reg <= '0;
        end else if (cke) begin
            stage_reg[0] <= s_data;
            for (int i = 1; i < LATENCY; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign m_data = stage_reg[LATENCY-1];

endmodule

// File: rtl/jelly_img_alpha_blend_layer.sv
// Two-layer alpha blend with frame-synchronous parameter adoption and a
// fixed four-cycle pipeline shared by data and control.
module jelly_img_alpha_blend_layer
    import jelly_img_alpha_blend_pkg::*;
#(
    parameter int                     COMPONENTS  = 3,
    parameter int                     DATA_WIDTH  = 8,
    parameter int                     ALPHA_WIDTH = 8,
    parameter int                     USER_WIDTH  = 0,
    parameter bit                     USE_VALID   = 1'b0,
    parameter logic [1:0]             INIT_MODE   = 2'd0,
    parameter logic [ALPHA_WIDTH-1:0] INIT_ALPHA  = '1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [1:0]             param_mode,
    input  logic [ALPHA_WIDTH-1:0] param_alpha,
    input  logic                   param_update_en,
    jelly_img_alpha_blend_layer_if.slave img,
    output logic [1:0]             active_mode,
    output logic [ALPHA_WIDTH-1:0] active_alpha
);

    localparam int USER_BITS  = user_bits(USER_WIDTH);
    localparam int CTRL_WIDTH = USER_BITS + 6;

    logic                   valid_in;
    logic                   frame_start;
    logic                   update_now;
    logic                   in_frame;
    logic                   frame_active_reg;
    blend_mode_t            active_mode_reg;
    logic [ALPHA_WIDTH-1:0] active_alpha_reg;
    blend_mode_t            sel_mode;
    logic [ALPHA_WIDTH-1:0] sel_alpha;
    logic [CTRL_WIDTH-1:0]  ctrl_in;
    logic [CTRL_WIDTH-1:0]  ctrl_out;
    logic [COMPONENTS-1:0][DATA_WIDTH-1:0] blend_data;

    assign valid_in    = USE_VALID ? img.s_img_valid : 1'b1;
    assign frame_start = cke & valid_in & img.s_img_line_first & img.s_img_pixel_first;
    assign update_now  = frame_start & param_update_en;

    // The frame-start pixel itself already uses the newly requested parameters.
    assign sel_mode  = update_now ? blend_mode_t'(param_mode) : active_mode_reg;
    assign sel_alpha = update_now ? param_alpha : active_alpha_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_mode_reg  <= blend_mode_t'(INIT_MODE);
            active_alpha_reg <= INIT_ALPHA;
            frame_active_reg <= 1'b0;
        end else begin
            if (update_now) begin
                active_mode_reg  <= blend_mode_t'(param_mode);
                active_alpha_reg <= param_alpha;
            end
            if (frame_start) begin
                frame_active_reg <= 1'b1;
            end
        end
    end

    assign active_mode  = active_mode_reg;
    assign active_alpha = active_alpha_reg;

    // Pixels of a frame interrupted by reset are suppressed until the next frame start.
    assign in_frame = frame_start | frame_active_reg;

    assign ctrl_in = {img.s_img_user,
                      valid_in,
                      img.s_img_line_first  & in_frame,
                      img.s_img_line_last   & in_frame,
                      img.s_img_pixel_first & in_frame,
                      img.s_img_pixel_last  & in_frame,
                      img.s_img_de          & in_frame};

    jelly_img_delay #(
        .LATENCY (BLEND_LATENCY),
        .WIDTH   (CTRL_WIDTH)
    ) u_ctrl_delay (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_data  (ctrl_in),
        .m_data  (ctrl_out)
    );

    assign {img.m_img_user, img.m_img_valid, img.m_img_line_first, img.m_img_line_last,
            img.m_img_pixel_first, img.m_img_pixel_last, img.m_img_de} = ctrl_out;

    genvar gi;
    generate
        for (gi = 0; gi < COMPONENTS; gi++) begin : g_unit
            jelly_img_alpha_blend_unit #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ALPHA_WIDTH (ALPHA_WIDTH)
            ) u_unit (
                .clk         (clk),
                .reset       (reset),
                .cke         (cke),
                .mode        (sel_mode),
                .const_alpha (sel_alpha),
                .pixel_alpha (img.s_img_alpha),
                .data0       (img.s_img_data0[gi*DATA_WIDTH +: DATA_WIDTH]),
                .data1       (img.s_img_data1[gi*DATA_WIDTH +: DATA_WIDTH]),
                .data        (blend_data[gi])
            );
        end
    endgenerate

    assign img.m_img_data = blend_data;

endmodule

// File: doc/jelly_img_alpha_blend_layer.md
JELLY_IMG_ALPHA_BLEND_LAYER -- requirements
Module: jelly_img_alpha_blend_layer

Interface
REQ-001 Parameter COMPONENTS, 3: colour components per pixel.
REQ-002 Parameter DATA_WIDTH, 8: bits per component.
REQ-003 Parameter ALPHA_WIDTH, 8: bits of constant and per-pixel alpha.
REQ-004 Parameter USER_WIDTH, 0: sideband width; port width USER_BITS = max(USER_WIDTH,1).
REQ-005 Parameter USE_VALID, 0: 0 = s_img_valid treated as 1.
REQ-006 Parameters INIT_MODE, 0 and INIT_ALPHA, all-ones: active register reset values.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 cke  in  1  clock enable; low freezes all state.
REQ-010 param_mode  in  2  requested mode: 0 bypass, 1 constant alpha, 2 per-pixel alpha, 3 per-pixel x constant.
REQ-011 param_alpha  in  ALPHA_WIDTH  requested constant alpha.
REQ-012 param_update_en  in  1  enables frame-start adoption of param_*.
REQ-013 s_img_line_first/line_last/pixel_first/pixel_last/de  in  1 each  image control.
REQ-014 s_img_user  in  USER_BITS; s_img_valid  in  1.
REQ-015 s_img_data0, s_img_data1  in  COMPONENTS*DATA_WIDTH  foreground, background.
REQ-016 s_img_alpha  in  ALPHA_WIDTH  per-pixel foreground alpha.
REQ-017 m_img_* (same control set as s_img_*), m_img_data  COMPONENTS*DATA_WIDTH  out.
REQ-018 active_mode  out  2, active_alpha  out  ALPHA_WIDTH  currently applied parameters.

Function
REQ-019 Frame start = cke & s_img_valid & s_img_line_first & s_img_pixel_first.
REQ-020 At frame start with param_update_en=1, active_mode/active_alpha load param_* and apply to that pixel onward; otherwise unchanged; mid-frame param changes have no effect.
REQ-021 Effective alpha a: mode1 = active_alpha; mode2 = s_img_alpha; mode3 = (s_img_alpha * ext(active_alpha)) >> ALPHA_WIDTH.
REQ-022 ext(x) = x + x[MSB], so all-ones maps to 2^ALPHA_WIDTH exactly.
REQ-023 Per component: out = d1 + (((d0 - d1) * ext(a) + 2^(ALPHA_WIDTH-1)) >>> ALPHA_WIDTH), signed difference, result within [min(d0,d1), max(d0,d1)], no saturation needed.
REQ-024 a=0 yields d1 exactly; a=all-ones yields d0 exactly.
REQ-025 Mode 0 outputs d0 unmodified.
REQ-026 Latency fixed at 4 cke-high cycles for all modes, data and control aligned.
REQ-027 Control and user signals pass through unmodified, delayed by latency.
REQ-028 USE_VALID=0: m_img_valid constant 1 after reset; USE_VALID=1: m_img_valid is delayed s_img_valid.
REQ-029 cke low: no register updates, frame-start detection suppressed.
REQ-030 No backpressure; one pixel accepted per cke-high cycle.

Reset
REQ-031 Reset clears all pipeline registers; m_img_* control, m_img_valid and m_img_data 0 until refilled.
REQ-032 Reset loads active_mode=INIT_MODE, active_alpha=INIT_ALPHA; reset takes priority over frame-start load and over cke.
REQ-033 Reset mid-frame discards in-flight pixels; no partial-frame output after release.

Structure
REQ-034 Mode encodings (BYPASS, CONST, PIXEL, PIXEL_CONST) live in shared package/header jelly_img_alpha_blend_pkg.
REQ-035 Per-component arithmetic in sub-module jelly_img_alpha_blend_unit (stages: capture, alpha select/multiply, diff multiply, round/add), instantiated COMPONENTS times.
REQ-036 Control delay uses jelly_img_delay with LATENCY 4.

Verification
REQ-037 Mode1, alpha=0x80, d0=200, d1=100 -> out 150 after 4 cycles; alpha=0xFF -> 200; alpha=0 -> 100.
REQ-038 Mode2, s_img_alpha ramp 0..255, d0=255, d1=0 -> out equals ext(alpha) rounding formula, monotonic, endpoints 0 and 255.
REQ-039 Mode3, s_img_alpha=0xFF, active_alpha=0x40, d0=0, d1=255 -> out 191.
REQ-040 param_mode changed 1->0 mid-frame -> mode1 output to frame end, bypass from next frame-start pixel; param_update_en=0 -> no change.
REQ-041 cke toggled randomly with USE_VALID=1 -> output stream identical to cke=1 reference, valid/de aligned.
REQ-042 Reset asserted mid-frame -> next cycle outputs 0, active_mode=INIT_MODE, clean restart on next frame.
